// File: rtl/wc_tile_sched.sv
// rtl/wc_tile_sched.sv - overlapping-tile scheduler and result buffer around the wc datapath
// Packs samples into stride-N_OUT tiles, launches them under FIFO credit and buffers results.
module wc_tile_sched #(
  parameter int DW    = 10,
  parameter int N_IN  = 8,
  parameter int N_OUT = 5,
  parameter int LAT   = 6,
  parameter int FD    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [N_IN*DW-1:0]    wc_d,
  input  logic [N_OUT*DW-1:0]   wc_z,
  output logic [N_OUT*DW-1:0]   m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy
);
  localparam int CW = $clog2(N_IN + 1);
  localparam int KW = $clog2(FD + 1);
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;

  typedef enum logic {FILL, PEND} state_t;
  state_t state, state_nx;

  logic                en, need_first, pend_last;
  logic                close, accept, launch, pop;
  logic [CW-1:0]       cnt, cnt_n, need, pad;
  logic [N_IN*DW-1:0]  win, win_sh, win_nx;
  logic [LAT-1:0]      tok_v, tok_l;
  logic                cap_v, cap_l;
  logic [N_OUT*DW-1:0] cap_z;
  logic [KW-1:0]       credit, count;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [N_OUT*DW-1:0] mem [FD];
  logic [FD-1:0]       lmem;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign s_ready = en & (state == FILL);
  assign accept  = s_ready & s_valid;
  assign launch  = (state == PEND) && (credit != '0);
  assign pop     = m_valid & m_ready;
  assign cnt_n   = cnt + 1'b1;
  assign need    = need_first ? CW'(N_IN) : CW'(N_OUT);
  assign pad     = need - cnt_n;
  // A short closing tile is padded by shifting zeros in behind the final sample
  assign win_sh  = {win[(N_IN-1)*DW-1:0], s_data};
  assign win_nx  = s_last ? (win_sh << (int'(pad) * DW)) : win_sh;

  assign m_valid = (count != '0);
  assign m_data  = mem[rd_ptr];
  assign m_last  = m_valid & lmem[rd_ptr];
  assign busy    = ~need_first | (cnt != '0) | (state == PEND) | (|tok_v) | cap_v | m_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    close    = 1'b0;
    case (state)
      FILL: if (accept && ((cnt_n == need) || s_last)) begin
        close    = 1'b1;
        state_nx = PEND;
      end
      PEND: if (launch) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en         <= 1'b0;
      cnt        <= '0;
      need_first <= 1'b1;
      pend_last  <= 1'b0;
      win        <= '0;
      wc_d       <= '0;
      tok_v      <= '0;
      tok_l      <= '0;
      cap_v      <= 1'b0;
      cap_l      <= 1'b0;
      cap_z      <= '0;
      credit     <= KW'(FD);
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lmem       <= '0;
      for (int i = 0; i < FD; i++) mem[i] <= '0;
    end else begin
      en <= 1'b1;
      if (accept) begin
        win <= win_nx;
        cnt <= cnt_n;
      end
      if (close) pend_last <= s_last;
      if (launch) begin
        wc_d       <= win;
        cnt        <= '0;
        need_first <= pend_last;
        if (pend_last) win <= '0;
      end
      // Token exit samples wc_z; the capture stage then writes the FIFO on the next edge
      tok_v <= {tok_v[LAT-2:0], launch};
      tok_l <= {tok_l[LAT-2:0], launch & pend_last};
      cap_v <= tok_v[LAT-1];
      cap_l <= tok_l[LAT-1];
      if (tok_v[LAT-1]) cap_z <= wc_z;
      if (cap_v) begin
        mem[wr_ptr]  <= cap_z;
        lmem[wr_ptr] <= cap_l;
        wr_ptr       <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count  <= count + KW'(cap_v) - KW'(pop);
      credit <= credit - KW'(launch) + KW'(pop);
    end
  end
endmodule
